fanout_eager_fork: RTL



---
 rtl/fanout_pkg.sv | 17 +
 rtl/fanout_eager_fork_if.sv | 20 ++
 rtl/fanout_fifo.sv | 73 +++++++
 rtl/fanout_eager_fork.sv | 69 ++++++
 4 files changed

// File: rtl/fanout_pkg.sv
// rtl/fanout_pkg.sv - shared constants and routing decode for the fanout blocks
package fanout_pkg;

  localparam int NUM_OUT = 20;
  localparam int DATA_W  = 17;
  localparam int SEL_W   = 8;
  localparam int SEL_BIT = 4;
  localparam int SELI_W  = $clog2(SEL_W);

  // A branch is routed when it is enabled and its select field marks it as used.
  function automatic logic is_active(input logic              en_bit,
                                     input logic [SEL_W-1:0]  sel_field,
                                     input logic [SELI_W-1:0] bit_idx = SELI_W'(SEL_BIT));
    return en_bit & sel_field[bit_idx];
  endfunction

endpackage

// File: rtl/fanout_eager_fork_if.sv
// rtl/fanout_eager_fork_if.sv - upstream token stream and per-branch broadcast stream
interface fanout_eager_fork_if #(
  parameter int NUM_OUT = fanout_pkg::NUM_OUT,
  parameter int DATA_W  = fanout_pkg::DATA_W
);

  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  out_data;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;

  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_valid);

  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_valid);

endinterface

// File: rtl/fanout_fifo.sv
// rtl/fanout_fifo.sv - input buffer with a registered head slot feeding the broadcast
module fanout_fifo #(
  parameter int DATA_W = fanout_pkg::DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              head_valid;
  logic              load;
  logic              from_mem;
  logic              bypass;
  logic              to_mem;

  // The head slot sits in front of the buffer, so total holding capacity is DEPTH+1.
  // An empty buffer forwards straight into the head slot to keep one-cycle latency.
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = ~head_valid;
  assign load     = ~head_valid | pop;
  assign from_mem = load & (count != '0);
  assign bypass   = load & (count == '0) & push;
  assign to_mem   = push & ~bypass;

  // Buffer storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (to_mem) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; pointers wrap naturally for a power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (to_mem)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (from_mem) rd_ptr <= rd_ptr + PTR_W'(1);
      if (to_mem & ~from_mem)      count <= count + CNT_W'(1);
      else if (from_mem & ~to_mem) count <= count - CNT_W'(1);
    end
  end

  // Head slot refill: oldest buffered entry first, otherwise the incoming token.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_data  <= '0;
      head_valid <= 1'b0;
    end else if (from_mem) begin
      head_data  <= mem[rd_ptr];
      head_valid <= 1'b1;
    end else if (bypass) begin
      head_data  <= push_data;
      head_valid <= 1'b1;
    end else if (load) begin
      head_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fanout_eager_fork.sv
// rtl/fanout_eager_fork.sv - eager-fork broadcaster with per-branch acceptance tracking
module fanout_eager_fork #(
  parameter int NUM_OUT = fanout_pkg::NUM_OUT,
  parameter int DATA_W  = fanout_pkg::DATA_W,
  parameter int SEL_W   = fanout_pkg::SEL_W,
  parameter int SEL_BIT = fanout_pkg::SEL_BIT,
  parameter int DEPTH   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_OUT-1:0]       en,
  input  logic [NUM_OUT*SEL_W-1:0] sel,
  fanout_eager_fork_if.slave       bus
);

  import fanout_pkg::*;

  logic [NUM_OUT-1:0] active;
  logic [NUM_OUT-1:0] done;
  logic [NUM_OUT-1:0] fire;
  logic [NUM_OUT-1:0] covered;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [DATA_W-1:0]  head_data;

  // Decode routed branches from the quasi-static config.
  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      active[i] = is_active(en[i], sel[i*SEL_W +: SEL_W], SELI_W'(SEL_BIT));
    end
  end

  // in_ready comes only from buffer occupancy, never from downstream ready.
  assign push          = bus.in_valid & ~full;
  assign bus.in_ready  = ~full;
  assign bus.out_data  = head_data;
  assign bus.out_valid = {NUM_OUT{~empty}} & active & ~done;

  // The head retires once every routed branch has taken it or takes it now;
  // branches that dropped out of the active mask no longer hold it back.
  assign fire    = bus.out_valid & bus.out_ready;
  assign covered = ~active | done | fire;
  assign pop     = ~empty & (&covered);

  // Track which branches already consumed the head so none sees it twice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    done <= '0;
    else if (pop) done <= '0;
    else          done <= done | fire;
  end

  fanout_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (bus.in_data),
    .full      (full),
    .empty     (empty),
    .head_data (head_data)
  );

endmodule
